elbeth_mux_n_to_1_pipe: RTL and testbench
=========================================

// Module: elbeth_mux_n_to_1_pipe
// PURPOSE
//  Parametrised N-to-1 datapath multiplexer with valid/ready handshake and a
//  2-entry registered output (skid) stage. Sits between multi-source producers
//  (forwarding paths, bus masters) and a single consumer in the ELBETH core.
//  Source is chosen by an explicit select (ARB_MODE=0) or a round-robin
//  arbiter (ARB_MODE=1). Transfer order is preserved; every output is registered.
// PARAMETERS
//  DATA_WIDTH  32  width of each data channel
//  NUM_INPUTS  4   number of input channels, >=2
//  ARB_MODE    0   0 = explicit select via sel; 1 = round-robin over in_valid
//  SEL_WIDTH   (localparam) = clog2(NUM_INPUTS)
// PORTS
//  clk       in   1                      rising-edge clock
//  rst_n     in   1                      async active-low reset
//  in_data   in   NUM_INPUTS*DATA_WIDTH  channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//  in_valid  in   NUM_INPUTS             per-channel valid
//  in_ready  out  NUM_INPUTS             per-channel ready
//  sel       in   SEL_WIDTH              channel select; ignored when ARB_MODE=1
//  out_data  out  DATA_WIDTH             registered output data
//  out_valid out  1                      output valid
//  out_ready in   1                      consumer ready
//  out_src   out  SEL_WIDTH              channel index that produced out_data
// BEHAVIOUR
//  - Reset (async assert, sync release): out_data=0, out_valid=0, out_src=0,
//    skid empty, rr pointer = NUM_INPUTS-1 (channel 0 has first priority).
//    Reset mid-operation discards all buffered data.
//  - Transfers: input i moves on in_valid[i] & in_ready[i]; output moves on
//    out_valid & out_ready. out_data/out_src stay stable while out_valid & !out_ready.
//  - Grant g: ARB_MODE=0 -> g=sel; sel>=NUM_INPUTS grants nothing, all in_ready=0.
//    ARB_MODE=1 -> first i with in_valid[i], searching from rr_ptr+1 upward
//    with wrap-around; no valid -> no grant.
//  - in_ready[i] = (i==g) & grant_exists & !full. full is a register bit, so no
//    combinational path out_ready -> in_ready. in_ready to non-granted channels is 0.
//  - rr_ptr <= g only on an accepted input transfer. It holds otherwise.
//  - Storage FSM: EMPTY / ONE (main reg valid) / TWO (main + skid valid).
//    acc = input transfer, pop = output transfer.
//    EMPTY: acc -> ONE (load main).
//    ONE: acc&pop -> ONE (reload main); acc&!pop -> TWO (load skid);
//         pop&!acc -> EMPTY.
//    TWO: pop -> ONE (skid -> main); acc is impossible (full=1).
//    out_valid = state!=EMPTY. full = state==TWO.
//  - Latency: 1 cycle from accepted input to out_valid when EMPTY.
//    Throughput is 1 transfer per cycle when out_ready stays high.
//  - out_src is carried alongside data through main and skid.
// TESTING
//  1 M0, sel=2, in_valid=4'b0100, data2=32'hDEADBEEF, out_ready=1 ->
//    next cycle out_valid=1, out_data=DEADBEEF, out_src=2; in_ready=4'b0100.
//  2 M0, out_ready=0, stream 3 words on ch1 -> 2 accepted, in_ready drops to 0
//    after the second word; raise out_ready -> words emerge in order, no loss.
//  3 M1, all 4 channels valid continuously, out_ready=1 ->
//    grants 0,1,2,3,0,... one per cycle, and out_src follows the same order.
//  4 M1, only ch3 valid -> granted every cycle. Then ch0+ch3 valid after a ch3
//    grant -> ch0 granted next (wrap-around).
//  5 M0, sel=NUM_INPUTS (NUM_INPUTS=3, sel=3) -> in_ready=0 on all channels,
//    out_valid stays 0.
//  6 State TWO, pulse rst_n low mid-cycle -> out_valid=0 and out_data=0
//    immediately; after release, the first grant (M1) goes to ch0.

Source files
------------

// File: rtl/elbeth_mux_n_to_1_pipe.sv
// rtl/elbeth_mux_n_to_1_pipe.sv - N-to-1 valid/ready mux with select or round-robin grant and 2-entry output stage
module elbeth_mux_n_to_1_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_INPUTS = 4,
  parameter int ARB_MODE   = 0,
  localparam int SEL_WIDTH = $clog2(NUM_INPUTS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  output logic [NUM_INPUTS-1:0]            in_ready,
  input  logic [SEL_WIDTH-1:0]             sel,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [SEL_WIDTH-1:0]             out_src
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_data_q, skid_data_q;
  logic [SEL_WIDTH-1:0]  main_src_q, skid_src_q;
  logic [SEL_WIDTH-1:0]  rr_ptr_q;

  logic                  grant_valid;
  logic [SEL_WIDTH-1:0]  grant_idx;
  logic [DATA_WIDTH-1:0] grant_data;
  logic                  full;
  logic                  acc;
  logic                  pop;
  logic                  load_main;
  logic                  load_skid;
  logic                  skid_to_main;
  int                    rr_idx;

  // Grant selection: explicit select, or first valid channel after rr_ptr with wrap.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    rr_idx      = 0;
    if (ARB_MODE == 0) begin
      if (int'(sel) < NUM_INPUTS) begin
        grant_valid = 1'b1;
        grant_idx   = sel;
      end
    end else begin
      for (int k = 1; k <= NUM_INPUTS; k++) begin
        rr_idx = (int'(rr_ptr_q) + k) % NUM_INPUTS;
        if (!grant_valid && in_valid[rr_idx]) begin
          grant_valid = 1'b1;
          grant_idx   = SEL_WIDTH'(rr_idx);
        end
      end
    end
  end

  assign grant_data = in_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign full       = (state_q == ST_TWO);

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      in_ready[i] = grant_valid && !full && (int'(grant_idx) == i);
    end
  end

  assign acc       = |(in_valid & in_ready);
  assign out_valid = (state_q != ST_EMPTY);
  assign pop       = out_valid && out_ready;
  assign out_data  = main_data_q;
  assign out_src   = main_src_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          state_d   = ST_ONE;
          load_main = 1'b1;
        end
      end
      ST_ONE: begin
        if (acc && pop) begin
          load_main = 1'b1;
        end else if (acc) begin
          state_d   = ST_TWO;
          load_skid = 1'b1;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop) begin
          state_d      = ST_ONE;
          skid_to_main = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Data and source travel together; skid only holds the word behind main.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data_q <= '0;
      main_src_q  <= '0;
      skid_data_q <= '0;
      skid_src_q  <= '0;
      rr_ptr_q    <= SEL_WIDTH'(NUM_INPUTS - 1);
    end else begin
      if (load_main) begin
        main_data_q <= grant_data;
        main_src_q  <= grant_idx;
      end else if (skid_to_main) begin
        main_data_q <= skid_data_q;
        main_src_q  <= skid_src_q;
      end
      if (load_skid) begin
        skid_data_q <= grant_data;
        skid_src_q  <= grant_idx;
      end
      if (acc) begin
        rr_ptr_q <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_elbeth_mux_n_to_1_pipe.sv
// tb/tb_elbeth_mux_n_to_1_pipe.sv - directed checks of select mode, round-robin mode and 3-input select mode
module tb_elbeth_mux_n_to_1_pipe;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [4*DW-1:0] a_in_data;
  logic [3:0]      a_in_valid, a_in_ready;
  logic [1:0]      a_sel, a_out_src;
  logic [DW-1:0]   a_out_data;
  logic            a_out_valid, a_out_ready;

  logic [4*DW-1:0] b_in_data;
  logic [3:0]      b_in_valid, b_in_ready;
  logic [1:0]      b_sel, b_out_src;
  logic [DW-1:0]   b_out_data;
  logic            b_out_valid, b_out_ready;

  logic [3*DW-1:0] c_in_data;
  logic [2:0]      c_in_valid, c_in_ready;
  logic [1:0]      c_sel, c_out_src;
  logic [DW-1:0]   c_out_data;
  logic            c_out_valid, c_out_ready;

  elbeth_mux_n_to_1_pipe #(.DATA_WIDTH(DW), .NUM_INPUTS(4), .ARB_MODE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .sel(a_sel), .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_src(a_out_src));

  elbeth_mux_n_to_1_pipe #(.DATA_WIDTH(DW), .NUM_INPUTS(4), .ARB_MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .sel(b_sel), .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_src(b_out_src));

  elbeth_mux_n_to_1_pipe #(.DATA_WIDTH(DW), .NUM_INPUTS(3), .ARB_MODE(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .sel(c_sel), .out_data(c_out_data), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_src(c_out_src));

  typedef struct {
    logic [1:0]  sel;
    logic [3:0]  iv;
    logic [31:0] base;
    logic [3:0]  exp_ir;
    logic        exp_ov;
    logic [31:0] exp_data;
    logic [1:0]  exp_src;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_in_data = '0; a_in_valid = '0; a_sel = '0; a_out_ready = 1'b1;
    b_in_data = '0; b_in_valid = '0; b_sel = '0; b_out_ready = 1'b1;
    c_in_data = '0; c_in_valid = '0; c_sel = '0; c_out_ready = 1'b1;

    vt[0] = '{2'd2, 4'b0100, 32'hDEADBEED, 4'b0100, 1'b1, 32'hDEADBEEF, 2'd2};
    vt[1] = '{2'd0, 4'b0001, 32'h11110000, 4'b0001, 1'b1, 32'h11110000, 2'd0};
    vt[2] = '{2'd3, 4'b0111, 32'h22220000, 4'b1000, 1'b0, 32'h0,         2'd0};
    vt[3] = '{2'd1, 4'b1111, 32'h33330000, 4'b0010, 1'b1, 32'h33330001, 2'd1};
    vt[4] = '{2'd3, 4'b1000, 32'h44440000, 4'b1000, 1'b1, 32'h44440003, 2'd3};
    vt[5] = '{2'd1, 4'b0000, 32'h55550000, 4'b0010, 1'b0, 32'h0,         2'd0};

    #1 rst_n = 1'b0;
    #1;
    chk("rst_a_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_a_out_data", a_out_data, 32'd0);
    chk("rst_a_out_src", 32'(a_out_src), 32'd0);
    chk("rst_b_out_valid", 32'(b_out_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Select mode, consumer always ready.
    for (int v = 0; v < 6; v++) begin
      a_sel = vt[v].sel;
      a_in_valid = vt[v].iv;
      for (int i = 0; i < 4; i++) a_in_data[i*DW +: DW] = vt[v].base + 32'(i);
      #1;
      chk($sformatf("vec%0d_in_ready", v), 32'(a_in_ready), 32'(vt[v].exp_ir));
      tick();
      chk($sformatf("vec%0d_out_valid", v), 32'(a_out_valid), 32'(vt[v].exp_ov));
      if (vt[v].exp_ov) begin
        chk($sformatf("vec%0d_out_data", v), a_out_data, vt[v].exp_data);
        chk($sformatf("vec%0d_out_src", v), 32'(a_out_src), 32'(vt[v].exp_src));
      end
    end

    // Backpressure: fill both entries, stall, then drain in order.
    a_sel = 2'd1; a_out_ready = 1'b0; a_in_valid = 4'b0010;
    a_in_data[1*DW +: DW] = 32'h0000A001;
    #1 chk("bp_ready_w1", 32'(a_in_ready), 32'h2);
    tick();
    chk("bp_data_w1", a_out_data, 32'h0000A001);
    a_in_data[1*DW +: DW] = 32'h0000A002;
    #1 chk("bp_ready_w2", 32'(a_in_ready), 32'h2);
    tick();
    chk("bp_ready_full", 32'(a_in_ready), 32'h0);
    a_in_data[1*DW +: DW] = 32'h0000A003;
    tick();
    chk("bp_stable_data", a_out_data, 32'h0000A001);
    chk("bp_stable_valid", 32'(a_out_valid), 32'd1);
    chk("bp_ready_still_full", 32'(a_in_ready), 32'h0);
    a_out_ready = 1'b1;
    tick();
    chk("bp_drain_w2", a_out_data, 32'h0000A002);
    chk("bp_ready_after_pop", 32'(a_in_ready), 32'h2);
    tick();
    chk("bp_drain_w3", a_out_data, 32'h0000A003);
    a_in_valid = 4'b0000;
    tick();
    chk("bp_empty", 32'(a_out_valid), 32'd0);

    // Round-robin with all channels requesting.
    for (int i = 0; i < 4; i++) b_in_data[i*DW +: DW] = 32'hC0000000 + 32'(i);
    b_in_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1 chk($sformatf("rr%0d_in_ready", k), 32'(b_in_ready), 32'(1) << (k % 4));
      tick();
      chk($sformatf("rr%0d_out_src", k), 32'(b_out_src), 32'(k % 4));
      chk($sformatf("rr%0d_out_data", k), b_out_data, 32'hC0000000 + 32'(k % 4));
    end

    // Single requester, then wrap-around from ch3 to ch0.
    b_in_valid = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("solo%0d_in_ready", k), 32'(b_in_ready), 32'h8);
      tick();
      chk($sformatf("solo%0d_out_src", k), 32'(b_out_src), 32'd3);
    end
    b_in_valid = 4'b1001;
    #1 chk("wrap_in_ready", 32'(b_in_ready), 32'h1);
    tick();
    chk("wrap_out_src", 32'(b_out_src), 32'd0);
    chk("wrap_next_in_ready", 32'(b_in_ready), 32'h8);
    tick();
    chk("wrap_next_out_src", 32'(b_out_src), 32'd3);

    // Out-of-range select on a 3-input instance.
    for (int i = 0; i < 3; i++) c_in_data[i*DW +: DW] = 32'hE0000000 + 32'(i);
    c_sel = 2'd3; c_in_valid = 3'b111;
    #1 chk("oob_in_ready", 32'(c_in_ready), 32'h0);
    tick();
    chk("oob_out_valid0", 32'(c_out_valid), 32'd0);
    tick();
    chk("oob_out_valid1", 32'(c_out_valid), 32'd0);
    c_sel = 2'd2;
    #1 chk("n3_sel2_in_ready", 32'(c_in_ready), 32'h4);
    tick();
    chk("n3_sel2_out_valid", 32'(c_out_valid), 32'd1);
    chk("n3_sel2_out_src", 32'(c_out_src), 32'd2);
    chk("n3_sel2_out_data", c_out_data, 32'hE0000002);

    // Reset while holding two entries.
    b_in_valid = 4'b1111; b_out_ready = 1'b0;
    tick();
    tick();
    chk("two_in_ready", 32'(b_in_ready), 32'h0);
    chk("two_out_valid", 32'(b_out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(b_out_valid), 32'd0);
    chk("midrst_out_data", b_out_data, 32'd0);
    chk("midrst_out_src", 32'(b_out_src), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    b_out_ready = 1'b1;
    #1 chk("postrst_in_ready", 32'(b_in_ready), 32'h1);
    tick();
    chk("postrst_out_valid", 32'(b_out_valid), 32'd1);
    chk("postrst_out_src", 32'(b_out_src), 32'd0);
    chk("postrst_out_data", b_out_data, 32'hC0000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
